serial_pattern_tx: RTL and testbench

- Serial bit-stream transmitter: latches a WIDTH-bit word and shifts it out MSB first on `dout`, one bit per clock.
- The frame is repeated a programmable number of times, with idle gaps between frames.
- Sits on the transmit side of the single-wire serial pattern link.
- Produces the bit streams that the link's Mealy sequence detectors consume; the line idles at 1.

---
 rtl/serial_pattern_pkg.sv | 22 ++
 rtl/piso_shift.sv | 27 ++
 rtl/serial_pattern_tx.sv | 177 +++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared state encoding and line constants for the serial pattern transmitter.
// The marker constant and PRE state exist only with SERIAL_PATTERN_TX_PREAMBLE_EN.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        ST_PRE  = 2'd1,
`endif
        ST_SEND = 2'd2,
        ST_GAPW = 2'd3
    } state_t;

    localparam int PRE_LEN = 6;

`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam logic [PRE_LEN-1:0] PREAMBLE = 6'b001010;
`endif

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register; load takes priority over shift.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: MSB-first payload, repeated frames with idle gaps.
// Optional 6-bit marker before every frame when SERIAL_PATTERN_TX_PREAMBLE_EN is defined.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH + PRE_LEN);
    localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP < 1) ? 0 : GAP - 1);
    // Gap counter parked at GAP marks the single done cycle
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP);
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'(PRE_LEN - 1);
    localparam state_t FRAME_FIRST = ST_PRE;
`else
    localparam state_t FRAME_FIRST = ST_SEND;
`endif

    state_t           state, state_n;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [CNT_W-1:0] frames, frames_n;
    logic [WIDTH-1:0] word, word_n;
    logic             load, shift, frame_end, sh_msb;
    logic             dout_n, vld_n, busy_n, done_n;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    logic [PRE_LEN-1:0] pre_sh;
`endif

    piso_shift #(.WIDTH(WIDTH)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (word_n),
        .msb   (sh_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            frames   <= '0;
            word     <= '0;
            dout     <= IDLE_LEVEL;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            gap_cnt  <= gap_cnt_n;
            frames   <= frames_n;
            word     <= word_n;
            dout     <= dout_n;
            dout_vld <= vld_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        frames_n  = frames;
        word_n    = word;
        load      = 1'b0;
        shift     = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    word_n    = data;
                    frames_n  = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    load      = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = FRAME_FIRST;
                end
            end
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            ST_PRE: begin
                if (bit_cnt == PRE_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = ST_SEND;
                end else begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                end
            end
`endif
            ST_SEND: begin
                shift = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    if (GAP > 0) begin
                        state_n   = ST_GAPW;
                        gap_cnt_n = '0;
                    end else begin
                        frame_end = 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                end
            end
            ST_GAPW: begin
                if (gap_cnt == GAP_END) begin
                    state_n   = ST_IDLE;
                    gap_cnt_n = '0;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                    frame_end = (gap_cnt == GAP_LAST);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Decided on the edge emitting the frame's last bit or gap cycle, so repeats have no bubble
        if (frame_end) begin
            if (frames > CNT_W'(1)) begin
                frames_n  = frames - CNT_W'(1);
                load      = 1'b1;
                bit_cnt_n = '0;
                gap_cnt_n = '0;
                state_n   = FRAME_FIRST;
            end else begin
                state_n   = ST_GAPW;
                gap_cnt_n = GAP_END;
            end
        end
    end

    always_comb begin
        dout_n = IDLE_LEVEL;
        vld_n  = 1'b0;
        busy_n = 1'b1;
        done_n = 1'b0;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        pre_sh = PREAMBLE << bit_cnt;
`endif
        case (state)
            ST_IDLE: busy_n = start;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            ST_PRE: begin
                dout_n = pre_sh[PRE_LEN-1];
                vld_n  = 1'b1;
            end
`endif
            ST_SEND: begin
                dout_n = sh_msb;
                vld_n  = 1'b1;
            end
            ST_GAPW: begin
                if (gap_cnt == GAP_END) begin
                    busy_n = 1'b0;
                    done_n = 1'b1;
                end
            end
            default: busy_n = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx against a per-edge line model.
// Honours SERIAL_PATTERN_TX_PREAMBLE_EN when the design is built with it.
module tb_serial_pattern_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic             dout, dout_vld, busy, done;

    int checks = 0;
    int passes = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data       (data),
        .repeat_cnt (repeat_cnt),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .busy       (busy),
        .done       (done)
    );

    // Expected {dout,dout_vld,busy,done} after each edge, from the accept edge onward.
    function automatic void build_run(input logic [WIDTH-1:0] d, input int r, input bit tail);
        int n;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        logic [5:0] mark;
        mark = 6'b001010;
`endif
        n = (r == 0) ? 1 : r;
        exp_q.push_back(4'b1010);
        for (int f = 0; f < n; f++) begin
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            for (int k = 5; k >= 0; k--) exp_q.push_back({mark[k], 3'b110});
`endif
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({d[i], 3'b110});
            for (int g = 0; g < GAP; g++) exp_q.push_back(4'b1010);
        end
        exp_q.push_back(4'b1001);
        if (tail) exp_q.push_back(4'b1000);
    endfunction

    task automatic kick(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] r);
        @(negedge clk);
        data = d;
        repeat_cnt = r;
        start = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        obs = {dout, dout_vld, busy, done};
        checks++;
        if (obs !== 4'b1000) $display("FAIL reset_async: got %b want 1000", obs);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        obs = {dout, dout_vld, busy, done};
        checks++;
        if (obs !== 4'b1000) $display("FAIL reset_held: got %b want 1000", obs);
        else passes++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        obs = {dout, dout_vld, busy, done};
        checks++;
        if (obs !== 4'b1000) $display("FAIL reset_idle: got %b want 1000", obs);
        else passes++;
    endtask

    task automatic test_single_a5();
        exp_q.delete();
        build_run(8'hA5, 1, 1'b1);
        kick(8'hA5, 4'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            obs = {dout, dout_vld, busy, done};
            checks++;
            if (obs !== exp_q[i]) $display("FAIL single_a5 edge %0d: got %b want %b", i, obs, exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_repeat_three();
        exp_q.delete();
        build_run(8'h0F, 3, 1'b1);
        kick(8'h0F, 4'd3);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            obs = {dout, dout_vld, busy, done};
            checks++;
            if (obs !== exp_q[i]) $display("FAIL repeat3 edge %0d: got %b want %b", i, obs, exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_repeat_zero_ignore();
        exp_q.delete();
        build_run(8'h3C, 0, 1'b1);
        kick(8'h3C, 4'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0 || i == 4) start = 1'b0;
            if (i == 3) begin
                data = 8'hFF;
                repeat_cnt = 4'd9;
                start = 1'b1;
            end
            obs = {dout, dout_vld, busy, done};
            checks++;
            if (obs !== exp_q[i]) $display("FAIL rep0_ignore edge %0d: got %b want %b", i, obs, exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_run();
        kick(8'h00, 4'd2);
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        obs = {dout, dout_vld, busy, done};
        checks++;
        if (obs !== 4'b1000) $display("FAIL midrun_reset: got %b want 1000", obs);
        else passes++;
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        build_run(8'h81, 1, 1'b1);
        kick(8'h81, 4'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            obs = {dout, dout_vld, busy, done};
            checks++;
            if (obs !== exp_q[i]) $display("FAIL after_reset_81 edge %0d: got %b want %b", i, obs, exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        build_run(8'h5A, 2, 1'b0);
        kick(8'h5A, 4'd2);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            obs = {dout, dout_vld, busy, done};
            checks++;
            if (obs !== exp_q[i]) $display("FAIL b2b_first edge %0d: got %b want %b", i, obs, exp_q[i]);
            else passes++;
        end
        exp_q.delete();
        build_run(8'hC3, 1, 1'b1);
        kick(8'hC3, 4'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            obs = {dout, dout_vld, busy, done};
            checks++;
            if (obs !== exp_q[i]) $display("FAIL b2b_second edge %0d: got %b want %b", i, obs, exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_max_repeat();
        logic [WIDTH-1:0] d;
        d = WIDTH'($urandom);
        exp_q.delete();
        build_run(d, (1 << CNT_W) - 1, 1'b1);
        kick(d, '1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            obs = {dout, dout_vld, busy, done};
            checks++;
            if (obs !== exp_q[i]) $display("FAIL max_repeat edge %0d: got %b want %b", i, obs, exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        int r;
        for (int t = 0; t < 6; t++) begin
            d = WIDTH'($urandom);
            r = int'($urandom_range(0, 5));
            exp_q.delete();
            build_run(d, r, 1'b1);
            kick(d, CNT_W'(r));
            for (int i = 0; i < exp_q.size(); i++) begin
                @(posedge clk);
                #1;
                if (i == 0) start = 1'b0;
                obs = {dout, dout_vld, busy, done};
                checks++;
                if (obs !== exp_q[i])
                    $display("FAIL random run %0d data %h rep %0d edge %0d: got %b want %b", t, d, r, i, obs, exp_q[i]);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_repeat_three();
        test_repeat_zero_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_max_repeat();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
